synfull_inject_queue: RTL and testbench

//  Per-endpoint elastic buffer between the SynFull DPI request stream and the packet_injector.
//  The SynFull source cannot be stalled. Requests are issued directly to the injector when it is

---
 rtl/synfull_inject_queue.sv | 102 ++++++++++
 tb/tb_synfull_inject_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/synfull_inject_queue.sv
// Elastic per-endpoint buffer between the unstallable SynFull request stream and the packet injector.
// Empty queue bypasses straight to the injector; otherwise requests queue in order, with run statistics.
module synfull_inject_queue #(
  parameter int DEPTH    = 64,
  parameter int PCK_SIZw = 4,
  parameter int NEw      = 4,
  parameter int DATAw    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid_i,
  input  logic [DATAw-1:0]           req_id_i,
  input  logic [PCK_SIZw-1:0]        req_size_i,
  input  logic [NEw-1:0]             req_dest_i,
  input  logic                       inj_ready_i,
  output logic                       pck_wr_o,
  output logic [DATAw-1:0]           pck_data_o,
  output logic [PCK_SIZw-1:0]        pck_size_o,
  output logic [NEw-1:0]             pck_dest_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [$clog2(DEPTH+1)-1:0] max_occ_o,
  output logic                       overflow_o,
  output logic [31:0]                drop_cnt_o,
  output logic [31:0]                sent_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int EW = DATAw + PCK_SIZw + NEw;

  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [OW-1:0] max_q, max_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   drop_q, drop_d;
  logic [31:0]   sent_q, sent_d;
  // Cleared by reset, set on the first edge after release: gates issue until then.
  logic          live_q;

  logic          empty, full, bypass, pop, wr_req, wr_en, drop;
  logic [EW-1:0] req_entry, head_entry;

  assign req_entry  = {req_id_i, req_size_i, req_dest_i};
  assign head_entry = mem_q[rd_ptr_q];

  always_comb begin
    empty    = (occ_q == '0);
    full     = (occ_q == OW'(DEPTH));
    bypass   = live_q & empty & req_valid_i & inj_ready_i;
    pop      = live_q & ~empty & inj_ready_i;
    wr_req   = req_valid_i & ~bypass;
    wr_en    = wr_req & (~full | pop);
    drop     = wr_req & full & ~pop;

    pck_wr_o = bypass | pop;
    {pck_data_o, pck_size_o, pck_dest_o} = empty ? req_entry : head_entry;

    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    occ_d    = occ_q + OW'(wr_en) - OW'(pop);
    max_d    = (occ_d > max_q) ? occ_d : max_q;
    ovf_d    = ovf_q | drop;
    drop_d   = (drop && drop_q != '1) ? drop_q + 32'd1 : drop_q;
    sent_d   = pck_wr_o ? sent_q + 32'd1 : sent_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      max_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      sent_q   <= '0;
      live_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      max_q    <= max_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      sent_q   <= sent_d;
      live_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= req_entry;
  end

  assign occupancy_o = occ_q;
  assign max_occ_o   = max_q;
  assign overflow_o  = ovf_q;
  assign drop_cnt_o  = drop_q;
  assign sent_cnt_o  = sent_q;

endmodule

// File: tb/tb_synfull_inject_queue.sv
// Bench for synfull_inject_queue: directed scenarios plus random traffic against a queue-based model.
module tb_synfull_inject_queue;

  localparam int DEPTH    = 8;
  localparam int PCK_SIZw = 4;
  localparam int NEw      = 4;
  localparam int DATAw    = 32;
  localparam int OW       = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                req_valid_i = 1'b0;
  logic [DATAw-1:0]    req_id_i = '0;
  logic [PCK_SIZw-1:0] req_size_i = '0;
  logic [NEw-1:0]      req_dest_i = '0;
  logic                inj_ready_i = 1'b0;
  logic                pck_wr_o;
  logic [DATAw-1:0]    pck_data_o;
  logic [PCK_SIZw-1:0] pck_size_o;
  logic [NEw-1:0]      pck_dest_o;
  logic [OW-1:0]       occupancy_o, max_occ_o;
  logic                overflow_o;
  logic [31:0]         drop_cnt_o, sent_cnt_o;

  synfull_inject_queue #(.DEPTH(DEPTH), .PCK_SIZw(PCK_SIZw), .NEw(NEw), .DATAw(DATAw)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_id_i(req_id_i), .req_size_i(req_size_i), .req_dest_i(req_dest_i),
    .inj_ready_i(inj_ready_i),
    .pck_wr_o(pck_wr_o), .pck_data_o(pck_data_o), .pck_size_o(pck_size_o), .pck_dest_o(pck_dest_o),
    .occupancy_o(occupancy_o), .max_occ_o(max_occ_o), .overflow_o(overflow_o),
    .drop_cnt_o(drop_cnt_o), .sent_cnt_o(sent_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATAw-1:0]    id;
    logic [PCK_SIZw-1:0] size;
    logic [NEw-1:0]      dest;
  } pkt_t;

  // Reference model state
  pkt_t        m_q[$];
  bit          m_live;
  int unsigned m_max, m_drop, m_sent;
  bit          m_ovf;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_live = 0; m_max = 0; m_drop = 0; m_sent = 0; m_ovf = 0;
  endtask

  task automatic check_stats();
    chk("occ",  occupancy_o, m_q.size());
    chk("max",  max_occ_o,   m_max);
    chk("ovf",  overflow_o,  m_ovf);
    chk("drop", drop_cnt_o,  m_drop);
    chk("sent", sent_cnt_o,  m_sent);
  endtask

  // One cycle: drive at posedge+1, check at posedge+3, advance model on the edge.
  task automatic step(input bit v, input logic [DATAw-1:0] id, input bit rdy);
    pkt_t p, exp_p;
    bit   exp_wr, byp;
    p.id   = id;
    p.size = PCK_SIZw'($urandom);
    p.dest = NEw'($urandom);
    req_valid_i = v; req_id_i = p.id; req_size_i = p.size; req_dest_i = p.dest;
    inj_ready_i = rdy;
    #2;
    byp    = m_live && rdy && v && (m_q.size() == 0);
    exp_wr = m_live && rdy && (m_q.size() > 0 || v);
    exp_p  = (m_q.size() > 0) ? m_q[0] : p;
    chk("pck_wr", pck_wr_o, exp_wr);
    if (exp_wr) begin
      chk("pck_data", pck_data_o, exp_p.id);
      chk("pck_size", pck_size_o, exp_p.size);
      chk("pck_dest", pck_dest_o, exp_p.dest);
    end
    check_stats();
    @(posedge clk);
    if (exp_wr) begin
      m_sent++;
      if (m_q.size() > 0) void'(m_q.pop_front());
    end
    if (v && !byp) begin
      if (m_q.size() < DEPTH) m_q.push_back(p);
      else begin
        m_ovf = 1;
        if (m_drop != 32'hFFFF_FFFF) m_drop++;
      end
    end
    if (m_q.size() > m_max) m_max = m_q.size();
    m_live = 1;
    #1;
  endtask

  // Assert reset asynchronously mid-cycle, check immediate effect, release one posedge+1 later.
  task automatic do_reset();
    inj_ready_i = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    model_clear();
    chk("rst_wr",  pck_wr_o, 0);
    check_stats();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, '0, 1);
  endtask

  initial begin
    model_clear();
    #2;
    chk("rst_wr0", pck_wr_o, 0);
    chk("rst_occ0", occupancy_o, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(0, '0, 1);

    // Empty-queue bypass
    step(1, 32'h11, 1);
    chk("byp_occ", occupancy_o, 0);

    // Queue 1..5 while stalled, then drain
    do_reset();
    for (int unsigned i = 1; i <= 5; i++) step(1, i, 0);
    for (int unsigned i = 0; i < 5; i++) step(0, '0, 1);
    chk("max5",  max_occ_o, 5);
    chk("sent5", sent_cnt_o, 5);
    chk("empty5", occupancy_o, 0);

    // Simultaneous pop and write
    do_reset();
    for (int unsigned i = 1; i <= 3; i++) step(1, i, 0);
    step(1, 32'h9, 1);
    chk("occ_hold", occupancy_o, 3);
    for (int unsigned i = 0; i < 3; i++) step(0, '0, 1);

    // Overflow, then full with concurrent pop and write
    do_reset();
    for (int unsigned i = 1; i <= DEPTH + 2; i++) step(1, i, 0);
    chk("full_occ",  occupancy_o, DEPTH);
    chk("full_ovf",  overflow_o, 1);
    chk("full_drop", drop_cnt_o, 2);
    step(1, 32'hAA, 1);
    chk("full_pw_occ",  occupancy_o, DEPTH);
    chk("full_pw_drop", drop_cnt_o, 2);
    for (int unsigned i = 0; i < DEPTH; i++) step(0, '0, 1);

    // Reset with entries queued
    for (int unsigned i = 1; i <= 3; i++) step(1, i, 0);
    do_reset();
    step(1, 32'h77, 1);
    chk("post_rst_sent", sent_cnt_o, 1);

    // Random traffic with varying pressure
    for (int unsigned ph = 0; ph < 12; ph++) begin
      int unsigned pv, pr;
      pv = $urandom_range(100, 20);
      pr = $urandom_range(90, 10);
      for (int unsigned c = 0; c < 200; c++)
        step($urandom_range(99) < pv, $urandom, $urandom_range(99) < pr);
      if (ph == 6) do_reset();
    end
    for (int unsigned i = 0; i < DEPTH + 2; i++) step(0, '0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
